// File: rtl/display_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment display path.
// Digit enables are one-cold; decimal point is active-low.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [3:0] SSD_ALL_OFF = 4'b1111;
    localparam logic [3:0] SSD_DIG0    = 4'b1110;
    localparam logic [3:0] SSD_DIG1    = 4'b1101;
    localparam logic [3:0] SSD_DIG2    = 4'b1011;
    localparam logic [3:0] SSD_DIG3    = 4'b0111;

    localparam logic DP_OFF = 1'b1;

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_e;

    function automatic logic [3:0] digit_enable(input digit_e idx);
        logic [3:0] en;
        case (idx)
            DIG0:    en = SSD_DIG0;
            DIG1:    en = SSD_DIG1;
            DIG2:    en = SSD_DIG2;
            default: en = SSD_DIG3;
        endcase
        return en;
    endfunction

    // True when this position and every more-significant nibble are zero.
    function automatic logic leading_zero(input logic [15:0] val, input digit_e idx);
        logic lz;
        case (idx)
            DIG1:    lz = (val[15:4] == 12'h000);
            DIG2:    lz = (val[15:8] == 8'h00);
            DIG3:    lz = (val[15:12] == 4'h0);
            default: lz = 1'b0;
        endcase
        return lz;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider: tick is high for one cycle out of every SCAN_DIV.
// Also reusable as a time base for debounce and blink logic.
module scan_prescaler #(
    parameter int SCAN_DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = $clog2(SCAN_DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit 7-segment scan controller: frame-latched shadow value, digit walk,
// leading-zero blanking and fully registered display outputs.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  ssd_ctl,
    output logic [3:0]  digit_out,
    output logic        dp_out,
    output logic        frame_start
);

    logic tick;

    scan_prescaler #(.SCAN_DIV(SCAN_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    digit_e      idx_q, idx_d;
    logic [15:0] shadow_val_q, shadow_val_d;
    logic [3:0]  shadow_dp_q, shadow_dp_d;
    logic        upd_q, wrap_q;
    logic        wrap;

    logic [3:0]  ssd_q, ssd_d;
    logic [3:0]  digit_q, digit_d;
    logic        dp_q, dp_d;
    logic        fs_q, fs_d;
    logic [3:0]  nibble;
    logic        blank_slot;

    // Stage 1: digit walk and frame latch on tick
    assign wrap = tick && (idx_q == DIG3);

    always_comb begin
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (tick) begin
            idx_d = digit_e'(idx_q + 2'd1);
        end
        if (wrap) begin
            shadow_val_d = value_in;
            shadow_dp_d  = dp_in;
        end
    end

    // Stage 2: output registers follow one cycle after the index moves
    assign nibble     = shadow_val_q[{idx_q, 2'b00} +: 4];
    assign blank_slot = blank_lz && leading_zero(shadow_val_q, idx_q);

    always_comb begin
        ssd_d   = ssd_q;
        digit_d = digit_q;
        dp_d    = dp_q;
        fs_d    = 1'b0;
        if (upd_q) begin
            digit_d = nibble;
            fs_d    = wrap_q;
            if (blank_slot) begin
                ssd_d = SSD_ALL_OFF;
                dp_d  = DP_OFF;
            end else begin
                ssd_d = digit_enable(idx_q);
                dp_d  = ~shadow_dp_q[idx_q];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= DIG3;
            shadow_val_q <= 16'h0000;
            shadow_dp_q  <= 4'b0000;
            upd_q        <= 1'b0;
            wrap_q       <= 1'b0;
            ssd_q        <= SSD_ALL_OFF;
            digit_q      <= 4'h0;
            dp_q         <= DP_OFF;
            fs_q         <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
            upd_q        <= tick;
            wrap_q       <= wrap;
            ssd_q        <= ssd_d;
            digit_q      <= digit_d;
            dp_q         <= dp_d;
            fs_q         <= fs_d;
        end
    end

    assign ssd_ctl     = ssd_q;
    assign digit_out   = digit_q;
    assign dp_out      = dp_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: SCAN_DIV=4 and SCAN_DIV=1 instances share stimulus
// and are checked against a tick-count reference model plus fixed vectors.
module tb_display_scan_ctrl;

    localparam int D4 = 4;
    localparam int D1 = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in;
    logic [3:0]  dp_in;
    logic        blank_lz;

    logic [3:0]  ssd4, dig4, ssd1, dig1;
    logic        dp4, fs4, dp1, fs1;

    always #5 clk = ~clk;

    display_scan_ctrl #(.SCAN_DIV(D4)) dut4 (
        .clk         (clk),
        .rst         (rst),
        .value_in    (value_in),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .ssd_ctl     (ssd4),
        .digit_out   (dig4),
        .dp_out      (dp4),
        .frame_start (fs4)
    );

    display_scan_ctrl #(.SCAN_DIV(D1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .value_in    (value_in),
        .dp_in       (dp_in),
        .blank_lz    (blank_lz),
        .ssd_ctl     (ssd1),
        .digit_out   (dig1),
        .dp_out      (dp1),
        .frame_start (fs1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state, index 0 = SCAN_DIV 4, index 1 = SCAN_DIV 1.
    int          m_n   [2];
    logic [15:0] m_sv  [2];
    logic [3:0]  m_sdp [2];
    logic [3:0]  m_ssd [2];
    logic [3:0]  m_dig [2];
    logic        m_dp  [2];
    logic        m_fs  [2];

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dp;
        logic        bl;
        logic [3:0]  ssd;
        logic [3:0]  dig;
        logic        dpo;
        logic        fs;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_n[i]   = 0;
            m_sv[i]  = 16'h0000;
            m_sdp[i] = 4'h0;
            m_ssd[i] = 4'hF;
            m_dig[i] = 4'h0;
            m_dp[i]  = 1'b1;
            m_fs[i]  = 1'b0;
        end
    endtask

    // Edge n after release: outputs refresh at edges k*d+1 (k-th tick, k>=1),
    // showing digit (k-1) mod 4; the frame is captured at the tick edge of digit 0.
    task automatic model_edge(input int i, input int d);
        int          k, idx;
        logic [15:0] upper;
        logic [3:0]  en;
        m_n[i]++;
        m_fs[i] = 1'b0;
        if (m_n[i] > d && (m_n[i] - 1) % d == 0) begin
            k        = (m_n[i] - 1) / d;
            idx      = (k - 1) % 4;
            upper    = m_sv[i] >> (4 * idx);
            m_dig[i] = upper[3:0];
            m_fs[i]  = (idx == 0);
            if (blank_lz && idx > 0 && upper == 16'h0000) begin
                m_ssd[i] = 4'hF;
                m_dp[i]  = 1'b1;
            end else begin
                en       = 4'b0001 << idx;
                m_ssd[i] = ~en;
                m_dp[i]  = ~m_sdp[i][idx];
            end
        end
        if (m_n[i] % d == 0 && ((m_n[i] / d) - 1) % 4 == 0) begin
            m_sv[i]  = value_in;
            m_sdp[i] = dp_in;
        end
    endtask

    task automatic chk_models();
        chk("mdl4_ssd", {12'h0, ssd4}, {12'h0, m_ssd[0]});
        chk("mdl4_dig", {12'h0, dig4}, {12'h0, m_dig[0]});
        chk("mdl4_dp",  {15'h0, dp4},  {15'h0, m_dp[0]});
        chk("mdl4_fs",  {15'h0, fs4},  {15'h0, m_fs[0]});
        chk("mdl1_ssd", {12'h0, ssd1}, {12'h0, m_ssd[1]});
        chk("mdl1_dig", {12'h0, dig1}, {12'h0, m_dig[1]});
        chk("mdl1_dp",  {15'h0, dp1},  {15'h0, m_dp[1]});
        chk("mdl1_fs",  {15'h0, fs1},  {15'h0, m_fs[1]});
    endtask

    task automatic step();
        model_edge(0, D4);
        model_edge(1, D1);
        @(posedge clk);
        @(negedge clk);
        chk_models();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ssd4"}, {12'h0, ssd4}, 16'h000F);
        chk({tag, "_dig4"}, {12'h0, dig4}, 16'h0000);
        chk({tag, "_dp4"},  {15'h0, dp4},  16'h0001);
        chk({tag, "_fs4"},  {15'h0, fs4},  16'h0000);
        chk({tag, "_ssd1"}, {12'h0, ssd1}, 16'h000F);
        chk({tag, "_dig1"}, {12'h0, dig1}, 16'h0000);
        chk({tag, "_dp1"},  {15'h0, dp1},  16'h0001);
        chk({tag, "_fs1"},  {15'h0, fs1},  16'h0000);
    endtask

    // Release reset, confirm four idle cycles, then digit 0 of 16'h12AB.
    task automatic startup_sequence(input string tag);
        value_in = 16'h12AB;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
        rst      = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk({tag, "_idle_ssd4"}, {12'h0, ssd4}, 16'h000F);
            chk({tag, "_idle_dp4"},  {15'h0, dp4},  16'h0001);
            chk({tag, "_idle_fs4"},  {15'h0, fs4},  16'h0000);
        end
    endtask

    initial begin
        tbl[0]  = '{16'h12AB, 4'h0, 1'b0, 4'b1110, 4'hB, 1'b1, 1'b1};
        tbl[1]  = '{16'h3456, 4'h0, 1'b0, 4'b1101, 4'hA, 1'b1, 1'b0};
        tbl[2]  = '{16'h3456, 4'h0, 1'b0, 4'b1011, 4'h2, 1'b1, 1'b0};
        tbl[3]  = '{16'h3456, 4'h0, 1'b0, 4'b0111, 4'h1, 1'b1, 1'b0};
        tbl[4]  = '{16'h3456, 4'h0, 1'b0, 4'b1110, 4'h6, 1'b1, 1'b1};
        tbl[5]  = '{16'h3456, 4'h0, 1'b0, 4'b1101, 4'h5, 1'b1, 1'b0};
        tbl[6]  = '{16'h3456, 4'h0, 1'b0, 4'b1011, 4'h4, 1'b1, 1'b0};
        tbl[7]  = '{16'h0005, 4'h4, 1'b1, 4'b0111, 4'h3, 1'b1, 1'b0};
        tbl[8]  = '{16'h0005, 4'h4, 1'b1, 4'b1110, 4'h5, 1'b1, 1'b1};
        tbl[9]  = '{16'h0005, 4'h4, 1'b1, 4'b1111, 4'h0, 1'b1, 1'b0};
        tbl[10] = '{16'h0005, 4'h4, 1'b1, 4'b1111, 4'h0, 1'b1, 1'b0};
        tbl[11] = '{16'h0000, 4'h0, 1'b1, 4'b1111, 4'h0, 1'b1, 1'b0};
        tbl[12] = '{16'h0000, 4'h0, 1'b1, 4'b1110, 4'h0, 1'b1, 1'b1};
        tbl[13] = '{16'h0000, 4'h0, 1'b1, 4'b1111, 4'h0, 1'b1, 1'b0};
        tbl[14] = '{16'h0000, 4'h0, 1'b1, 4'b1111, 4'h0, 1'b1, 1'b0};
        tbl[15] = '{16'h0000, 4'hA, 1'b0, 4'b0111, 4'h0, 1'b1, 1'b0};
        tbl[16] = '{16'h0000, 4'h0, 1'b0, 4'b1110, 4'h0, 1'b1, 1'b1};
        tbl[17] = '{16'h0000, 4'h0, 1'b0, 4'b1101, 4'h0, 1'b0, 1'b0};
        tbl[18] = '{16'h0000, 4'h0, 1'b0, 4'b1011, 4'h0, 1'b1, 1'b0};
        tbl[19] = '{16'h0000, 4'h0, 1'b0, 4'b0111, 4'h0, 1'b0, 1'b0};

        value_in = 16'h12AB;
        dp_in    = 4'h0;
        blank_lz = 1'b0;
        rst      = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_vals("rst_hold");

        startup_sequence("boot");

        // Each row: inputs for one slot, checked right after the slot's refresh edge.
        for (int r = 0; r < 20; r++) begin
            value_in = tbl[r].v;
            dp_in    = tbl[r].dp;
            blank_lz = tbl[r].bl;
            step();
            chk($sformatf("vec%0d_ssd", r), {12'h0, ssd4}, {12'h0, tbl[r].ssd});
            chk($sformatf("vec%0d_dig", r), {12'h0, dig4}, {12'h0, tbl[r].dig});
            chk($sformatf("vec%0d_dp", r),  {15'h0, dp4},  {15'h0, tbl[r].dpo});
            chk($sformatf("vec%0d_fs", r),  {15'h0, fs4},  {15'h0, tbl[r].fs});
            repeat (3) step();
        end

        // Move to the middle of the digit-2 slot, then hit reset asynchronously.
        value_in = 16'h9876;
        repeat (10) step();
        chk("mid_slot_ssd4", {12'h0, ssd4}, 16'h000B);
        #2 rst = 1'b1;
        #1 chk_reset_vals("async_rst");
        model_reset();
        @(negedge clk);
        chk_reset_vals("rst_held");
        @(negedge clk);

        startup_sequence("restart");
        step();
        chk("restart_ssd4", {12'h0, ssd4}, 16'h000E);
        chk("restart_dig4", {12'h0, dig4}, 16'h000B);
        chk("restart_fs4",  {15'h0, fs4},  16'h0001);

        for (int c = 0; c < 600; c++) begin
            logic [15:0] mask;
            case ($urandom_range(0, 4))
                0:       mask = 16'hFFFF;
                1:       mask = 16'h0FFF;
                2:       mask = 16'h00FF;
                3:       mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                value_in = 16'($urandom) & mask;
                dp_in    = 4'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                blank_lz = 1'($urandom);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
